alu_operand_loader: RTL
=======================

# alu_operand_loader

Front-end stage that feeds the registered ALU datapath from board switches and one push-button. The operator sets switches and presses the button three times to capture operand A, operand B and the 3-bit opcode in sequence; the block then presents them as stable registered outputs with a one-cycle `valid` strobe. It sits between the raw board I/O and the ALU input register stage, and shields that stage from bounce and metastability.

## Interface
- `N`, 4, operand width.
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required to accept a button level change (≥2).
- `clk` input 1: single system clock.
- `reset` input 1: synchronous, active-high.
- `sw` input N: operand switches, asynchronous.
- `op_sw` input 3: opcode switches, asynchronous.
- `btn_load` input 1: raw push-button, active-high, asynchronous, bouncy.
- `btn_clear` input 1: raw push-button, active-high, asynchronous; returns to operand-A entry.
- `a_q` output N: captured operand A.
- `b_q` output N: captured operand B.
- `op_q` output 3: captured opcode.
- `valid` output 1: one-cycle pulse when a full A/B/op set has just been captured.
- `stage` output 2: current FSM state encoding, for the status LEDs.

## Operation
- Both buttons: 2-flop synchronizer, then a debouncer. The debouncer counts cycles while the synchronized level differs from the debounced level. It flips the debounced level after `DEBOUNCE_CYCLES` consecutive differing cycles, and clears the counter whenever the levels agree.
- `load_pulse` / `clear_pulse`: one-cycle pulse on each debounced 0→1 transition; release edges are ignored.
- `sw` and `op_sw` pass through a 2-flop synchronizer and are sampled on the pulse cycle.
- FSM states and encodings: `S_A`=0, `S_B`=1, `S_OP`=2, `S_DONE`=3.
  - `S_A` + `load_pulse`: `a_q`←sw, go to `S_B`.
  - `S_B` + `load_pulse`: `b_q`←sw, go to `S_OP`.
  - `S_OP` + `load_pulse`: `op_q`←op_sw, set `valid`, go to `S_DONE`.
  - `S_DONE` + `load_pulse`: `a_q`←sw, go to `S_B`, which starts a new set. `b_q` and `op_q` keep their old values until overwritten.
- `clear_pulse` in any state: go to `S_A`. Data outputs are kept and no `valid` is produced.
  - If `clear_pulse` and `load_pulse` occur in the same cycle, clear wins and nothing is captured.
- `valid` is registered. It is high for exactly one cycle per completed set and never two cycles in a row.
- Captured values are unsigned and unmodified; the block performs no arithmetic.

## Timing
- Reset values: `a_q`=0, `b_q`=0, `op_q`=0, `valid`=0, `stage`=0 (`S_A`), all debounce counters and levels 0, synchronizers 0.
- Raw button rising, held clean, to pulse: pulse is high in cycle 2+`DEBOUNCE_CYCLES` after the first sampling edge. Capture and state update happen at the end of that cycle.
- `valid` is high in the cycle after the `S_OP` pulse, coincident with the updated `op_q` and `stage`=3.
- Switch changes must be stable for ≥2 cycles before the pulse to be captured.
- Bounce glitches shorter than `DEBOUNCE_CYCLES` produce no pulse. A button held down produces exactly one pulse.
- `reset` asserted mid-sequence, including on a pulse cycle: outputs return to reset values on the next edge; the pulse is discarded; debounced levels restart at 0.
  - If a button is still held after reset releases, it produces one pulse after debounce. This is intended.

## Structure
- Shared package `alu_io_pkg`:
  - `loader_state_t` enum (2-bit, encodings above).
  - `OP_W`=3.
  - Default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce`:
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `btn_raw` → `level`, `rise_pulse`.
  - Contains the synchronizer, counter and edge detect; instantiated twice.
- Top holds the switch synchronizers, the FSM, the capture registers and `valid`.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and N=4.
- Clean sequence: sw=0101 press, sw=0011 press, op_sw=010 press. Expect `a_q`=5, `b_q`=3, `op_q`=2, one `valid` pulse, `stage`=3.
- Bounce: `btn_load` toggles every 2 cycles for 20 cycles, then holds high. Expect exactly one capture, exactly 6 cycles after hold start.
- Held button: hold `btn_load` for 100 cycles in `S_A`. Expect one capture, `stage`=1, no further advance.
- Clear: in `S_OP`, press `btn_clear`. Expect `stage`=0, `a_q`/`b_q` unchanged, no `valid`. Then a simultaneous load+clear: expect `stage`=0 and no capture.
- Wrap: from `S_DONE`, press load with sw=1111. Expect `a_q`=15, `stage`=1, `b_q` still 3.
- Reset mid-sequence: assert `reset` in `S_B` on the pulse cycle. Expect all outputs 0 and `stage`=0 next cycle, with `b_q` not updated.

Source files
------------

// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU board-I/O front end.
package alu_io_pkg;

    localparam int OP_W = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-counting debouncer,
// and a registered one-cycle pulse on each debounced press.
module btn_debounce
    import alu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle;
    // any agreeing cycle throws the partial count away.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures operand A, operand B and the opcode from board switches on
// successive debounced button presses and presents them as registered outputs.
module alu_operand_loader
    import alu_io_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    sw,
    input  logic [OP_W-1:0] op_sw,
    input  logic            btn_load,
    input  logic            btn_clear,
    output logic [N-1:0]    a_q,
    output logic [N-1:0]    b_q,
    output logic [OP_W-1:0] op_q,
    output logic            valid,
    output logic [1:0]      stage
);

    logic load_pulse;
    logic clear_pulse;
    logic load_level;
    logic clear_level;
    logic unused_levels;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_load),
        .level      (load_level),
        .rise_pulse (load_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_clear),
        .level      (clear_level),
        .rise_pulse (clear_pulse)
    );

    // Debounced levels are only needed by the status logic of other boards.
    assign unused_levels = load_level ^ clear_level;

    logic [N-1:0]    sw_s1_q;
    logic [N-1:0]    sw_s2_q;
    logic [OP_W-1:0] op_s1_q;
    logic [OP_W-1:0] op_s2_q;

    loader_state_t   state_q;
    loader_state_t   state_d;
    logic [N-1:0]    a_d;
    logic [N-1:0]    b_d;
    logic [OP_W-1:0] op_d;
    logic            valid_q;
    logic            valid_d;

    // Clear has priority over a coincident load so nothing is captured.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = 1'b0;
        if (clear_pulse) begin
            state_d = S_A;
        end else if (load_pulse) begin
            case (state_q)
                S_A, S_DONE: begin
                    a_d     = sw_s2_q;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_s2_q;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = op_s2_q;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            op_s1_q <= '0;
            op_s2_q <= '0;
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            op_s1_q <= op_sw;
            op_s2_q <= op_s1_q;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
    assign stage = state_q;

endmodule
